// File: rtl/hash_wr_sched.sv
`default_nettype none
// ============================================================================
// hash_wr_sched : port-B write arbiter (U/H round-robin) and clear sequencer
//                 for the three hash-table RAMs.            Rev 1.0
// ============================================================================
module hash_wr_sched #(
   parameter int unsigned DEPTH1 = 2140,
   parameter int unsigned DEPTH2 = 1070,
   parameter int unsigned DEPTH3 = 535
) (
   input  logic        Sys_clk,
   input  logic        Rst_n,
   input  logic        clr_start,
   output logic        clr_busy,
   output logic        clr_done,
   input  logic        u_req,
   input  logic [1:0]  u_tbl,
   input  logic [11:0] u_addr,
   input  logic [3:0]  u_data,
   output logic        u_ack,
   input  logic        h_req,
   input  logic [1:0]  h_tbl,
   input  logic [11:0] h_addr,
   input  logic [3:0]  h_data,
   output logic        h_ack,
   output logic        err,
   output logic        enb_1,
   output logic        web_1,
   output logic [11:0] addrb_1,
   output logic [3:0]  dib_1,
   output logic        enb_2,
   output logic        web_2,
   output logic [10:0] addrb_2,
   output logic [3:0]  dib_2,
   output logic        enb_3,
   output logic        web_3,
   output logic [9:0]  addrb_3,
   output logic [3:0]  dib_3
);

   localparam logic [11:0] C_D1   = 12'(DEPTH1);
   localparam logic [11:0] C_D2   = 12'(DEPTH2);
   localparam logic [11:0] C_D3   = 12'(DEPTH3);
   localparam logic [11:0] C_LAST = 12'(DEPTH1 - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [11:0] cnt_q, cnt_d;
   logic        rr_q, rr_d;          // 0: U favoured, 1: H favoured
   logic        u_ack_q, u_ack_d, h_ack_q, h_ack_d;
   logic        busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic        en1_q, en1_d, en2_q, en2_d, en3_q, en3_d;
   logic [11:0] addrb1_q, addrb1_d;
   logic [10:0] addrb2_q, addrb2_d;
   logic [9:0]  addrb3_q, addrb3_d;
   logic [3:0]  dib1_q, dib1_d, dib2_q, dib2_d, dib3_q, dib3_d;

   logic        u_elig, h_elig, gnt_u, gnt_h, clr_wr;
   logic [11:0] clr_addr, sel_addr;
   logic [1:0]  sel_tbl;
   logic [3:0]  sel_data;

   // A requester acked this cycle is still holding req; it must not be re-granted.
   assign u_elig = u_req && !u_ack_q;
   assign h_elig = h_req && !h_ack_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rr_d     = rr_q;
      u_ack_d  = 1'b0;
      h_ack_d  = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      err_d    = err_q;
      en1_d    = 1'b0;
      en2_d    = 1'b0;
      en3_d    = 1'b0;
      addrb1_d = addrb1_q;
      addrb2_d = addrb2_q;
      addrb3_d = addrb3_q;
      dib1_d   = dib1_q;
      dib2_d   = dib2_q;
      dib3_d   = dib3_q;
      clr_wr   = 1'b0;
      clr_addr = 12'd0;
      gnt_u    = 1'b0;
      gnt_h    = 1'b0;
      sel_tbl  = 2'd0;
      sel_addr = 12'd0;
      sel_data = 4'd0;

      case (state_q)
         ST_IDLE: begin
            if (clr_start) begin
               state_d = ST_CLEAR;
               cnt_d   = 12'd0;
               clr_wr  = 1'b1;
            end else begin
               gnt_u = u_elig && (!h_elig || !rr_q);
               gnt_h = h_elig && (!u_elig || rr_q);
            end
         end
         ST_CLEAR: begin
            if (cnt_q == C_LAST) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end else begin
               cnt_d    = cnt_q + 12'd1;
               clr_wr   = 1'b1;
               clr_addr = cnt_q + 12'd1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // cnt_q tracks the address currently presented on the port-B outputs.
      if (clr_wr) begin
         busy_d = 1'b1;
         if (clr_addr < C_D1) begin
            en1_d    = 1'b1;
            addrb1_d = clr_addr;
            dib1_d   = 4'd0;
         end
         if (clr_addr < C_D2) begin
            en2_d    = 1'b1;
            addrb2_d = clr_addr[10:0];
            dib2_d   = 4'd0;
         end
         if (clr_addr < C_D3) begin
            en3_d    = 1'b1;
            addrb3_d = clr_addr[9:0];
            dib3_d   = 4'd0;
         end
      end

      if (gnt_u || gnt_h) begin
         rr_d     = gnt_u;
         u_ack_d  = gnt_u;
         h_ack_d  = gnt_h;
         sel_tbl  = gnt_u ? u_tbl  : h_tbl;
         sel_addr = gnt_u ? u_addr : h_addr;
         sel_data = gnt_u ? u_data : h_data;
         case (sel_tbl)
            2'd1: begin
               if (sel_addr < C_D1) begin
                  en1_d    = 1'b1;
                  addrb1_d = sel_addr;
                  dib1_d   = sel_data;
               end else err_d = 1'b1;
            end
            2'd2: begin
               if (sel_addr < C_D2) begin
                  en2_d    = 1'b1;
                  addrb2_d = sel_addr[10:0];
                  dib2_d   = sel_data;
               end else err_d = 1'b1;
            end
            2'd3: begin
               if (sel_addr < C_D3) begin
                  en3_d    = 1'b1;
                  addrb3_d = sel_addr[9:0];
                  dib3_d   = sel_data;
               end else err_d = 1'b1;
            end
            default: err_d = 1'b1;
         endcase
      end
   end

   always_ff @(posedge Sys_clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 12'd0;
         rr_q     <= 1'b0;
         u_ack_q  <= 1'b0;
         h_ack_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         en1_q    <= 1'b0;
         en2_q    <= 1'b0;
         en3_q    <= 1'b0;
         addrb1_q <= 12'd0;
         addrb2_q <= 11'd0;
         addrb3_q <= 10'd0;
         dib1_q   <= 4'd0;
         dib2_q   <= 4'd0;
         dib3_q   <= 4'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rr_q     <= rr_d;
         u_ack_q  <= u_ack_d;
         h_ack_q  <= h_ack_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
         en1_q    <= en1_d;
         en2_q    <= en2_d;
         en3_q    <= en3_d;
         addrb1_q <= addrb1_d;
         addrb2_q <= addrb2_d;
         addrb3_q <= addrb3_d;
         dib1_q   <= dib1_d;
         dib2_q   <= dib2_d;
         dib3_q   <= dib3_d;
      end
   end

   assign clr_busy = busy_q;
   assign clr_done = done_q;
   assign u_ack    = u_ack_q;
   assign h_ack    = h_ack_q;
   assign err      = err_q;
   assign enb_1    = en1_q;
   assign web_1    = en1_q;
   assign addrb_1  = addrb1_q;
   assign dib_1    = dib1_q;
   assign enb_2    = en2_q;
   assign web_2    = en2_q;
   assign addrb_2  = addrb2_q;
   assign dib_2    = dib2_q;
   assign enb_3    = en3_q;
   assign web_3    = en3_q;
   assign addrb_3  = addrb3_q;
   assign dib_3    = dib3_q;

endmodule
`default_nettype wire

// File: tb/tb_hash_wr_sched.sv
`default_nettype none
// ============================================================================
// tb_hash_wr_sched : directed bench with per-requester expected-write queues.
//                    Rev 1.0
// ============================================================================
module tb_hash_wr_sched;

   logic        Sys_clk = 1'b0;
   logic        Rst_n = 1'b0;
   logic        clr_start = 1'b0;
   logic        clr_busy, clr_done;
   logic        u_req = 1'b0, h_req = 1'b0;
   logic [1:0]  u_tbl = '0, h_tbl = '0;
   logic [11:0] u_addr = '0, h_addr = '0;
   logic [3:0]  u_data = '0, h_data = '0;
   logic        u_ack, h_ack, err;
   logic        enb_1, web_1, enb_2, web_2, enb_3, web_3;
   logic [11:0] addrb_1;
   logic [10:0] addrb_2;
   logic [9:0]  addrb_3;
   logic [3:0]  dib_1, dib_2, dib_3;

   hash_wr_sched dut (
      .Sys_clk(Sys_clk), .Rst_n(Rst_n), .clr_start(clr_start),
      .clr_busy(clr_busy), .clr_done(clr_done),
      .u_req(u_req), .u_tbl(u_tbl), .u_addr(u_addr), .u_data(u_data), .u_ack(u_ack),
      .h_req(h_req), .h_tbl(h_tbl), .h_addr(h_addr), .h_data(h_data), .h_ack(h_ack),
      .err(err),
      .enb_1(enb_1), .web_1(web_1), .addrb_1(addrb_1), .dib_1(dib_1),
      .enb_2(enb_2), .web_2(web_2), .addrb_2(addrb_2), .dib_2(dib_2),
      .enb_3(enb_3), .web_3(web_3), .addrb_3(addrb_3), .dib_3(dib_3)
   );

   always #5 Sys_clk = ~Sys_clk;

   typedef struct {
      logic [1:0]  tbl;
      logic [11:0] addr;
      logic [3:0]  data;
      bit          valid;
   } exp_t;

   exp_t sb_u[$];
   exp_t sb_h[$];
   int   n_chk = 0;
   int   n_err = 0;
   bit   prev_u = 1'b0, prev_h = 1'b0;
   int   busy_n, en1_n, en2_n, en3_n, done_n, done_at, ack_at, bad, early;
   bit   found;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t mk(input logic [1:0] t, input logic [11:0] a, input logic [3:0] d);
      exp_t e;
      e.tbl   = t;
      e.addr  = a;
      e.data  = d;
      e.valid = (t == 2'd1 && a < 12'd2140) || (t == 2'd2 && a < 12'd1070) ||
                (t == 2'd3 && a < 12'd535);
      return e;
   endfunction

   task automatic check_write(input string who, input exp_t e);
      logic [5:0] en_exp;
      en_exp = 6'b000000;
      if (e.valid)
         en_exp = (e.tbl == 2'd1) ? 6'b110000 : (e.tbl == 2'd2) ? 6'b001100 : 6'b000011;
      chk({who, "_en"}, 32'({enb_1, web_1, enb_2, web_2, enb_3, web_3}), 32'(en_exp));
      if (!e.valid) chk({who, "_err"}, 32'(err), 32'd1);
      else if (e.tbl == 2'd1) begin
         chk({who, "_addrb_1"}, 32'(addrb_1), 32'(e.addr));
         chk({who, "_dib_1"}, 32'(dib_1), 32'(e.data));
      end else if (e.tbl == 2'd2) begin
         chk({who, "_addrb_2"}, 32'(addrb_2), 32'(e.addr));
         chk({who, "_dib_2"}, 32'(dib_2), 32'(e.data));
      end else begin
         chk({who, "_addrb_3"}, 32'(addrb_3), 32'(e.addr));
         chk({who, "_dib_3"}, 32'(dib_3), 32'(e.data));
      end
   endtask

   // One clock; any ack is matched against the head of that requester's queue.
   task automatic cyc();
      @(posedge Sys_clk);
      #1;
      if (u_ack) begin
         chk("u_ack_b2b", 32'(prev_u), 32'd0);
         chk("u_ack_expected", 32'(sb_u.size() > 0), 32'd1);
         if (sb_u.size() > 0) check_write("u", sb_u.pop_front());
      end
      if (h_ack) begin
         chk("h_ack_b2b", 32'(prev_h), 32'd0);
         chk("h_ack_expected", 32'(sb_h.size() > 0), 32'd1);
         if (sb_h.size() > 0) check_write("h", sb_h.pop_front());
      end
      prev_u = u_ack;
      prev_h = h_ack;
   endtask

   task automatic do_reset();
      Rst_n = 1'b0;
      clr_start = 1'b0;
      u_req = 1'b0;
      h_req = 1'b0;
      sb_u.delete();
      sb_h.delete();
      prev_u = 1'b0;
      prev_h = 1'b0;
      repeat (2) @(posedge Sys_clk);
      @(negedge Sys_clk);
      Rst_n = 1'b1;
      @(posedge Sys_clk);
      #1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();
      chk("rst_flags", 32'({clr_busy, clr_done, u_ack, h_ack, err}), 32'd0);
      chk("rst_en", 32'({enb_1, web_1, enb_2, web_2, enb_3, web_3}), 32'd0);
      chk("rst_addrb_1", 32'(addrb_1), 32'd0);
      chk("rst_addrb23", 32'({addrb_2, addrb_3}), 32'd0);
      chk("rst_dib", 32'({dib_1, dib_2, dib_3}), 32'd0);

      // single write, then boundary-valid writes to tables 3 and 1
      u_req = 1'b1; u_tbl = 2'd2; u_addr = 12'h05A; u_data = 4'h9;
      sb_u.push_back(mk(u_tbl, u_addr, u_data));
      cyc();
      chk("t1_u_ack", 32'(u_ack), 32'd1);
      chk("t1_err", 32'(err), 32'd0);
      u_req = 1'b0;
      cyc();
      chk("t1_ack_one_cycle", 32'(u_ack), 32'd0);
      u_req = 1'b1; u_tbl = 2'd3; u_addr = 12'd534; u_data = 4'hF;
      sb_u.push_back(mk(u_tbl, u_addr, u_data));
      cyc();
      chk("t1_u_ack_t3", 32'(u_ack), 32'd1);
      u_req = 1'b0;
      h_req = 1'b1; h_tbl = 2'd1; h_addr = 12'd2139; h_data = 4'h3;
      sb_h.push_back(mk(h_tbl, h_addr, h_data));
      cyc();
      chk("t1_h_ack_t1", 32'(h_ack), 32'd1);
      h_req = 1'b0;
      cyc();
      chk("t1_err_still0", 32'(err), 32'd0);

      // both requesters held: grants alternate U,H,... from reset
      do_reset();
      u_req = 1'b1; u_tbl = 2'd1; u_addr = 12'h100; u_data = 4'h1;
      h_req = 1'b1; h_tbl = 2'd1; h_addr = 12'h200; h_data = 4'h2;
      sb_u.push_back(mk(u_tbl, u_addr, u_data));
      sb_h.push_back(mk(h_tbl, h_addr, h_data));
      for (int i = 0; i < 8; i++) begin
         cyc();
         chk("alt_u", 32'(u_ack), 32'(i % 2 == 0));
         chk("alt_h", 32'(h_ack), 32'(i % 2 == 1));
         if (u_ack) begin
            u_addr = u_addr + 12'd1; u_data = u_data + 4'd1;
            sb_u.push_back(mk(u_tbl, u_addr, u_data));
         end
         if (h_ack) begin
            h_addr = h_addr + 12'd1; h_data = h_data + 4'd1;
            sb_h.push_back(mk(h_tbl, h_addr, h_data));
         end
      end
      u_req = 1'b0;
      h_req = 1'b0;
      sb_u.delete();
      sb_h.delete();
      cyc();
      cyc();

      // clear with a pending U request and a redundant clr_start mid-clear
      u_req = 1'b1; u_tbl = 2'd1; u_addr = 12'd7; u_data = 4'h5;
      sb_u.push_back(mk(u_tbl, u_addr, u_data));
      clr_start = 1'b1;
      cyc();
      clr_start = 1'b0;
      busy_n = 0; en1_n = 0; en2_n = 0; en3_n = 0; done_n = 0;
      done_at = -1; ack_at = -1; bad = 0; early = 0;
      for (int i = 0; i < 2200; i++) begin
         if (clr_busy) busy_n++;
         if (enb_1 && !u_ack) begin
            if (addrb_1 != 12'(en1_n) || dib_1 != 4'd0 || !web_1) bad++;
            en1_n++;
         end
         if (enb_2) begin
            if (addrb_2 != 11'(i) || dib_2 != 4'd0 || !web_2) bad++;
            en2_n++;
         end
         if (enb_3) begin
            if (addrb_3 != 10'(i) || dib_3 != 4'd0 || !web_3) bad++;
            en3_n++;
         end
         if (clr_done) begin done_n++; done_at = i; end
         if (u_ack) begin
            if (done_n == 0) early++;
            ack_at = i;
            u_req = 1'b0;
         end
         if (i == 500) clr_start = 1'b1;
         if (i == 501) clr_start = 1'b0;
         cyc();
      end
      chk("clr_busy_len", 32'(busy_n), 32'd2140);
      chk("clr_en1_len", 32'(en1_n), 32'd2140);
      chk("clr_en2_len", 32'(en2_n), 32'd1070);
      chk("clr_en3_len", 32'(en3_n), 32'd535);
      chk("clr_addr_data", 32'(bad), 32'd0);
      chk("clr_done_count", 32'(done_n), 32'd1);
      chk("clr_done_cycle", 32'(done_at), 32'd2140);
      chk("clr_u_ack_early", 32'(early), 32'd0);
      chk("clr_u_ack_cycle", 32'(ack_at), 32'd2142);

      // invalid requests: out-of-range address, then table 0
      h_req = 1'b1; h_tbl = 2'd3; h_addr = 12'd535; h_data = 4'h1;
      sb_h.push_back(mk(h_tbl, h_addr, h_data));
      cyc();
      chk("inv_h_ack", 32'(h_ack), 32'd1);
      h_req = 1'b0;
      cyc();
      u_req = 1'b1; u_tbl = 2'd0; u_addr = 12'd5; u_data = 4'h2;
      sb_u.push_back(mk(u_tbl, u_addr, u_data));
      cyc();
      chk("inv_u_ack", 32'(u_ack), 32'd1);
      u_req = 1'b0;
      repeat (3) cyc();
      chk("inv_err_sticky", 32'(err), 32'd1);

      // asynchronous reset at clear address 1000, then restart
      clr_start = 1'b1;
      cyc();
      clr_start = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 1100; i++) begin
         if (enb_1 && addrb_1 == 12'd1000) begin
            found = 1'b1;
            break;
         end
         cyc();
      end
      chk("rst_mid_reached", 32'(found), 32'd1);
      #2 Rst_n = 1'b0;
      #1;
      chk("rst_mid_flags", 32'({clr_busy, clr_done, u_ack, h_ack, err}), 32'd0);
      chk("rst_mid_en", 32'({enb_1, web_1, enb_2, web_2, enb_3, web_3}), 32'd0);
      chk("rst_mid_addrb_1", 32'(addrb_1), 32'd0);
      @(negedge Sys_clk);
      Rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         if (clr_done || clr_busy) bad++;
      end
      chk("rst_mid_no_done", 32'(bad), 32'd0);
      clr_start = 1'b1;
      cyc();
      clr_start = 1'b0;
      chk("restart_busy", 32'(clr_busy), 32'd1);
      chk("restart_en", 32'({enb_1, enb_2, enb_3}), 32'b111);
      chk("restart_addrb_1", 32'(addrb_1), 32'd0);
      done_n = 0;
      done_at = -1;
      for (int i = 1; i < 2200; i++) begin
         cyc();
         if (clr_done) begin done_n++; done_at = i; end
      end
      chk("restart_done_count", 32'(done_n), 32'd1);
      chk("restart_done_cycle", 32'(done_at), 32'd2140);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
`default_nettype wire
